lc4_exec_wb: RTL and testbench
==============================

// Module: lc4_exec_wb
// PURPOSE
//  Execute->writeback stage directly downstream of the LC4 ALU; 64-bit datapath.
//  Registers the ALU result with a valid/ready handshake through a 2-entry skid buffer.
//  Owns the architectural carry flag (fed back to the ALU carry input) and the NZP register.
//  Produces register-file write port signals.
// PARAMETERS
//  WORD_SIZE  64  datapath width; matches ALU WORD_SIZE
//  REG_BITS   3   register-select width
// PORTS
//  clk            in   1          clock, all state on rising edge
//  rst_n          in   1          asynchronous reset, active-low
//  i_valid        in   1          upstream ALU result valid
//  o_ready        out  1          stage can accept this cycle
//  i_insn         in   16         instruction that produced i_alu_result
//  i_r1data       in   WORD_SIZE  rs operand as presented to the ALU
//  i_r2data       in   WORD_SIZE  rt operand as presented to the ALU
//  i_alu_result   in   WORD_SIZE  ALU o_result
//  i_wsel         in   REG_BITS   destination register
//  i_regfile_we   in   1          instruction writes the register file
//  i_nzp_we       in   1          instruction updates NZP
//  o_carry        out  1          carry flag, drives ALU carry input
//  o_valid        out  1          writeback entry valid
//  i_ready        in   1          downstream/regfile accepts entry
//  o_wsel         out  REG_BITS   write register select
//  o_wdata        out  WORD_SIZE  write data
//  o_regfile_we   out  1          = o_valid & i_ready & entry.regfile_we
//  o_nzp          out  3          architectural NZP {N,Z,P}
// BEHAVIOUR
//  - Reset (rst_n=0, async): main/skid valid=0, o_valid=0, o_ready=1, o_carry=0,
//    o_nzp=3'b010, o_wsel=0, o_wdata=0, o_regfile_we=0.
//  - Accept = i_valid & o_ready. Retire = o_valid & i_ready.
//  - Entry fields: wdata, wsel, regfile_we, nzp_we, nzp_calc.
//  - nzp_calc at accept: N=result[WORD_SIZE-1]; Z=(result==0); P otherwise; exactly one bit set.
//  - o_ready registered: o_ready = ~skid_valid. Latency accept->o_valid = 1 cycle.
//  - Buffer states (main,skid): EMPTY(0,0), ONE(1,0), FULL(1,1).
//  - Transitions:
//    - EMPTY+accept -> ONE.
//    - ONE+accept+retire -> ONE (main reloaded).
//    - ONE+accept only -> FULL (new entry to skid).
//    - ONE+retire only -> EMPTY.
//    - FULL+retire -> ONE (skid moves to main, same cycle).
//  - No accept is possible in FULL; i_valid held upstream (i_* stable until accepted).
//  - Order is strictly FIFO; no entry dropped or duplicated.
//  - Carry update on accept, not retire, so the next ALU op sees it the following cycle:
//    - SDR1 (insn[15:12]=0001, insn[5:3]=011): carry <= i_r1data[0].
//    - SDR2 (insn[15:12]=1010, insn[5:4]=11): carry <= i_r2data[0].
//    - Any other accepted insn, or no accept: carry holds.
//  - NZP update on retire when entry.nzp_we=1: o_nzp <= entry.nzp_calc; otherwise holds.
//  - o_wsel/o_wdata show the main entry while o_valid; hold last values when empty.
//  - Reset mid-operation discards both entries; carry/NZP return to reset values.
// CONFIGURATION
//  LC4_WB_PARITY_EN:
//  - Defined: adds port o_wdata_par out 1 = ^o_wdata (even parity), computed at
//    accept and stored per entry; reset 0.
//  - Undefined: port absent, no parity storage.
// TESTING
//  1. Reset: rst_n=0 mid-cycle -> immediately o_valid=0, o_ready=1, o_carry=0, o_nzp=010.
//  2. ADD, result=64'h5, nzp_we=1, i_ready=1 -> o_valid next cycle, o_wdata=5, o_nzp=001 after retire.
//  3. i_ready=0, three back-to-back valids of 1, 2, 3 -> 1 and 2 accepted, o_ready=0.
//     Release i_ready -> retire order 1, 2, 3.
//  4. SDR1, r1data=64'h3 -> o_carry=1 next cycle.
//     Then SDR2, r2data=64'h2 -> o_carry=0 next cycle; ALU sees each value on the following op.
//  5. result=64'h8000_0000_0000_0000 with nzp_we=0 -> o_nzp unchanged.
//     Same value with nzp_we=1 -> o_nzp=100.
//  6. LC4_WB_PARITY_EN defined, result=64'h7 -> o_wdata_par=1; result=64'h3 -> o_wdata_par=0.

Source files
------------

// File: rtl/lc4_exec_wb.sv
// LC4 execute->writeback stage: 2-entry skid buffer, carry flag, NZP register.
// Optional LC4_WB_PARITY_EN adds a per-entry even-parity bit on o_wdata.
module lc4_exec_wb #(
   parameter int WORD_SIZE = 64,
   parameter int REG_BITS  = 3
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 i_valid,
   output logic                 o_ready,
   input  logic [15:0]          i_insn,
   input  logic [WORD_SIZE-1:0] i_r1data,
   input  logic [WORD_SIZE-1:0] i_r2data,
   input  logic [WORD_SIZE-1:0] i_alu_result,
   input  logic [REG_BITS-1:0]  i_wsel,
   input  logic                 i_regfile_we,
   input  logic                 i_nzp_we,
   output logic                 o_carry,
   output logic                 o_valid,
   input  logic                 i_ready,
   output logic [REG_BITS-1:0]  o_wsel,
   output logic [WORD_SIZE-1:0] o_wdata,
   output logic                 o_regfile_we,
   output logic [2:0]           o_nzp
`ifdef LC4_WB_PARITY_EN
   ,
   output logic                 o_wdata_par
`endif
);

   typedef struct packed {
      logic [WORD_SIZE-1:0] wdata;
      logic [REG_BITS-1:0]  wsel;
      logic                 regfile_we;
      logic                 nzp_we;
      logic [2:0]           nzp_calc;
`ifdef LC4_WB_PARITY_EN
      logic                 par;
`endif
   } entry_t;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t state, state_n;
   entry_t main_e, skid_e, new_e;
   logic   accept, retire;
   logic   ld_main_new, ld_main_skid, ld_skid;
   logic   is_sdr1, is_sdr2;
   logic   res_neg, res_zero;
   logic   unused_ok;

   assign o_valid = (state != EMPTY);
   assign o_ready = (state != FULL);
   assign accept  = i_valid & o_ready;
   assign retire  = o_valid & i_ready;

   assign res_neg  = i_alu_result[WORD_SIZE-1];
   assign res_zero = (i_alu_result == '0);

   always_comb begin
      new_e            = '0;
      new_e.wdata      = i_alu_result;
      new_e.wsel       = i_wsel;
      new_e.regfile_we = i_regfile_we;
      new_e.nzp_we     = i_nzp_we;
      new_e.nzp_calc   = {res_neg, res_zero, ~res_neg & ~res_zero};
`ifdef LC4_WB_PARITY_EN
      new_e.par        = ^i_alu_result;
`endif
   end

   always_comb begin
      state_n      = state;
      ld_main_new  = 1'b0;
      ld_main_skid = 1'b0;
      ld_skid      = 1'b0;
      unique case (state)
         EMPTY: begin
            if (accept) begin
               state_n     = ONE;
               ld_main_new = 1'b1;
            end
         end
         ONE: begin
            if (accept & retire) begin
               ld_main_new = 1'b1;
            end else if (accept) begin
               state_n = FULL;
               ld_skid = 1'b1;
            end else if (retire) begin
               state_n = EMPTY;
            end
         end
         FULL: begin
            if (retire) begin
               state_n      = ONE;
               ld_main_skid = 1'b1;
            end
         end
         default: state_n = EMPTY;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= EMPTY;
         main_e <= '0;
         skid_e <= '0;
      end else begin
         state <= state_n;
         if (ld_main_new)
            main_e <= new_e;
         else if (ld_main_skid)
            main_e <= skid_e;
         if (ld_skid)
            skid_e <= new_e;
      end
   end

   // Carry changes at accept so the very next ALU op already sees it.
   assign is_sdr1 = (i_insn[15:12] == 4'b0001) && (i_insn[5:3] == 3'b011);
   assign is_sdr2 = (i_insn[15:12] == 4'b1010) && (i_insn[5:4] == 2'b11);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         o_carry <= 1'b0;
      end else if (accept) begin
         if (is_sdr1)
            o_carry <= i_r1data[0];
         else if (is_sdr2)
            o_carry <= i_r2data[0];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         o_nzp <= 3'b010;
      else if (retire && main_e.nzp_we)
         o_nzp <= main_e.nzp_calc;
   end

   assign o_wsel       = main_e.wsel;
   assign o_wdata      = main_e.wdata;
   assign o_regfile_we = o_valid & i_ready & main_e.regfile_we;
`ifdef LC4_WB_PARITY_EN
   assign o_wdata_par  = main_e.par;
`endif

   assign unused_ok = ^{i_insn[11:6], i_insn[2:0],
                        i_r1data[WORD_SIZE-1:1],
                        i_r2data[WORD_SIZE-1:1]};

endmodule

// File: tb/tb_lc4_exec_wb.sv
// Bench for lc4_exec_wb: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_lc4_exec_wb;
   localparam int W = 64;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        i_valid = 1'b0;
   logic        o_ready;
   logic [15:0] i_insn = '0;
   logic [W-1:0] i_r1data = '0;
   logic [W-1:0] i_r2data = '0;
   logic [W-1:0] i_alu_result = '0;
   logic [2:0]  i_wsel = '0;
   logic        i_regfile_we = 1'b0;
   logic        i_nzp_we = 1'b0;
   logic        o_carry;
   logic        o_valid;
   logic        i_ready = 1'b0;
   logic [2:0]  o_wsel;
   logic [W-1:0] o_wdata;
   logic        o_regfile_we;
   logic [2:0]  o_nzp;
`ifdef LC4_WB_PARITY_EN
   logic        o_wdata_par;
`endif

   lc4_exec_wb #(.WORD_SIZE(W), .REG_BITS(3)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .i_valid(i_valid),
      .o_ready(o_ready),
      .i_insn(i_insn),
      .i_r1data(i_r1data),
      .i_r2data(i_r2data),
      .i_alu_result(i_alu_result),
      .i_wsel(i_wsel),
      .i_regfile_we(i_regfile_we),
      .i_nzp_we(i_nzp_we),
      .o_carry(o_carry),
      .o_valid(o_valid),
      .i_ready(i_ready),
      .o_wsel(o_wsel),
      .o_wdata(o_wdata),
      .o_regfile_we(o_regfile_we),
      .o_nzp(o_nzp)
`ifdef LC4_WB_PARITY_EN
      ,
      .o_wdata_par(o_wdata_par)
`endif
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   task automatic check(input string name, input logic [63:0] act,
                        input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   typedef struct {
      logic [W-1:0] wdata;
      logic [2:0]   wsel;
      logic         rfwe;
      logic         nzpwe;
   } m_entry_t;

   m_entry_t   mq[$];
   logic       m_carry = 1'b0;
   logic [2:0] m_nzp = 3'b010;

   function automatic logic [2:0] nzp_of(input logic [W-1:0] r);
      if ($signed(r) < 0) return 3'b100;
      if (r == 0) return 3'b010;
      return 3'b001;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mq.delete();
         m_carry = 1'b0;
         m_nzp = 3'b010;
      end else begin
         automatic bit acc = i_valid && (mq.size() < 2);
         automatic bit ret = (mq.size() > 0) && i_ready;
         automatic m_entry_t e;
         if (ret) begin
            e = mq.pop_front();
            if (e.nzpwe) m_nzp = nzp_of(e.wdata);
         end
         if (acc) begin
            e.wdata = i_alu_result;
            e.wsel  = i_wsel;
            e.rfwe  = i_regfile_we;
            e.nzpwe = i_nzp_we;
            mq.push_back(e);
            if (i_insn[15:12] == 4'h1 && i_insn[5:3] == 3'd3)
               m_carry = i_r1data[0];
            else if (i_insn[15:12] == 4'hA && i_insn[5:4] == 2'd3)
               m_carry = i_r2data[0];
         end
      end
   end

   logic [W-1:0] last_wdata = '0;
   logic [2:0]   last_wsel = '0;

   always @(negedge clk) begin
      if (!rst_n) begin
         last_wdata = '0;
         last_wsel = '0;
      end else begin
         automatic int sz = mq.size();
         automatic bit rf = 1'b0;
         if (sz > 0) begin
            last_wdata = mq[0].wdata;
            last_wsel = mq[0].wsel;
            rf = mq[0].rfwe && i_ready;
         end
         check("m_valid", 64'(o_valid), 64'(sz > 0));
         check("m_ready", 64'(o_ready), 64'(sz < 2));
         check("m_wdata", o_wdata, last_wdata);
         check("m_wsel", 64'(o_wsel), 64'(last_wsel));
         check("m_rfwe", 64'(o_regfile_we), 64'(rf));
         check("m_carry", 64'(o_carry), 64'(m_carry));
         check("m_nzp", 64'(o_nzp), 64'(m_nzp));
`ifdef LC4_WB_PARITY_EN
         check("m_par", 64'(o_wdata_par), 64'(^last_wdata));
`endif
      end
   end

   task automatic drive(input logic [15:0] insn, input logic [W-1:0] r1,
                        input logic [W-1:0] r2, input logic [W-1:0] res,
                        input logic [2:0] ws, input logic rf,
                        input logic nz);
      i_insn = insn;
      i_r1data = r1;
      i_r2data = r2;
      i_alu_result = res;
      i_wsel = ws;
      i_regfile_we = rf;
      i_nzp_we = nz;
      i_valid = 1'b1;
   endtask

   task automatic send(input logic [15:0] insn, input logic [W-1:0] r1,
                       input logic [W-1:0] r2, input logic [W-1:0] res,
                       input logic [2:0] ws, input logic rf,
                       input logic nz);
      bit done = 1'b0;
      drive(insn, r1, r2, res, ws, rf, nz);
      for (int k = 0; k < 20; k++) begin
         automatic logic rdy = o_ready;
         @(posedge clk);
         #1;
         if (rdy) begin
            done = 1'b1;
            break;
         end
      end
      if (!done) check("accept_timeout", 64'(0), 64'(1));
      i_valid = 1'b0;
   endtask

   localparam logic [15:0] ADD  = 16'h1000;
   localparam logic [15:0] SDR1 = 16'h1018;
   localparam logic [15:0] SDR2 = 16'hA030;
   localparam logic [W-1:0] NEG = 64'h8000_0000_0000_0000;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(posedge clk);
      #1;
      check("rst_valid", 64'(o_valid), 64'(0));
      check("rst_ready", 64'(o_ready), 64'(1));
      check("rst_carry", 64'(o_carry), 64'(0));
      check("rst_nzp", 64'(o_nzp), 64'(3'b010));
      check("rst_wdata", o_wdata, 64'(0));
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // single ADD, positive result
      i_ready = 1'b1;
      send(ADD, 64'd2, 64'd3, 64'h5, 3'd2, 1'b1, 1'b1);
      check("add_valid", 64'(o_valid), 64'(1));
      check("add_wdata", o_wdata, 64'h5);
      check("add_wsel", 64'(o_wsel), 64'(2));
      check("add_rfwe", 64'(o_regfile_we), 64'(1));
      @(posedge clk);
      #1;
      check("add_nzp", 64'(o_nzp), 64'(3'b001));
      check("add_empty", 64'(o_valid), 64'(0));
      check("add_hold", o_wdata, 64'h5);

      // back-pressure: 1 and 2 fill buffer, 3 stalls
      i_ready = 1'b0;
      send(ADD, 0, 0, 64'd1, 3'd1, 1'b1, 1'b1);
      send(ADD, 0, 0, 64'd2, 3'd2, 1'b1, 1'b1);
      drive(ADD, 0, 0, 64'd3, 3'd3, 1'b1, 1'b1);
      check("full_ready", 64'(o_ready), 64'(0));
      repeat (2) @(posedge clk);
      #1;
      check("stall_ready", 64'(o_ready), 64'(0));
      check("stall_wdata", o_wdata, 64'd1);
      check("stall_rfwe", 64'(o_regfile_we), 64'(0));
      i_ready = 1'b1;
      check("ord1", o_wdata, 64'd1);
      @(posedge clk);
      #1;
      check("ord2", o_wdata, 64'd2);
      check("ord2_ready", 64'(o_ready), 64'(1));
      @(posedge clk);
      #1;
      check("ord3", o_wdata, 64'd3);
      check("ord3_wsel", 64'(o_wsel), 64'(3));
      i_valid = 1'b0;
      @(posedge clk);
      #1;
      check("ord_drained", 64'(o_valid), 64'(0));

      // carry via SDR1 / SDR2, other insns hold it
      send(SDR1, 64'h3, 64'h0, 64'h1, 3'd4, 1'b1, 1'b0);
      check("sdr1_carry", 64'(o_carry), 64'(1));
      send(ADD, 64'h0, 64'h0, 64'h4, 3'd4, 1'b1, 1'b0);
      check("add_carry_hold", 64'(o_carry), 64'(1));
      send(16'h1010, 64'h0, 64'h0, 64'h4, 3'd4, 1'b1, 1'b0);
      check("nonsdr_hold", 64'(o_carry), 64'(1));
      send(SDR2, 64'h1, 64'h2, 64'h1, 3'd5, 1'b1, 1'b0);
      check("sdr2_carry", 64'(o_carry), 64'(0));
      send(SDR2, 64'h0, 64'h7, 64'h1, 3'd5, 1'b0, 1'b0);
      check("sdr2_carry1", 64'(o_carry), 64'(1));
      check("nowe_rfwe", 64'(o_regfile_we), 64'(0));
      @(posedge clk);
      #1;

      // NZP gating
      send(ADD, 0, 0, NEG, 3'd6, 1'b1, 1'b0);
      @(posedge clk);
      #1;
      check("nzp_nowe", 64'(o_nzp), 64'(3'b001));
      send(ADD, 0, 0, NEG, 3'd6, 1'b1, 1'b1);
      @(posedge clk);
      #1;
      check("nzp_neg", 64'(o_nzp), 64'(3'b100));
      send(ADD, 0, 0, 64'h0, 3'd6, 1'b1, 1'b1);
      @(posedge clk);
      #1;
      check("nzp_zero", 64'(o_nzp), 64'(3'b010));

`ifdef LC4_WB_PARITY_EN
      send(ADD, 0, 0, 64'h7, 3'd1, 1'b1, 1'b0);
      check("par7", 64'(o_wdata_par), 64'(1));
      send(ADD, 0, 0, 64'h3, 3'd1, 1'b1, 1'b0);
      check("par3", 64'(o_wdata_par), 64'(0));
      @(posedge clk);
      #1;
`endif

      // asynchronous reset with a full buffer
      i_ready = 1'b0;
      send(SDR1, 64'h1, 0, 64'h9, 3'd7, 1'b1, 1'b1);
      send(ADD, 0, 0, 64'hA, 3'd7, 1'b1, 1'b1);
      check("pre_rst_full", 64'(o_ready), 64'(0));
      #3;
      rst_n = 1'b0;
      #1;
      check("arst_valid", 64'(o_valid), 64'(0));
      check("arst_ready", 64'(o_ready), 64'(1));
      check("arst_carry", 64'(o_carry), 64'(0));
      check("arst_nzp", 64'(o_nzp), 64'(3'b010));
      check("arst_wdata", o_wdata, 64'(0));
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      i_ready = 1'b1;
      send(ADD, 0, 0, 64'h11, 3'd3, 1'b1, 1'b1);
      check("post_rst_wdata", o_wdata, 64'h11);
      repeat (3) @(posedge clk);
      #1;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
